// File: rtl/seq_divider_n.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro SEQDIV_DIVZERO_EN adds a div_zero flag and a one-cycle divide-by-zero path.
module seq_divider_n #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divider,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
`ifdef SEQDIV_DIVZERO_EN
    output logic         div_zero,
`endif
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;

    logic [N:0]    shift_r;
    logic          ge;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;
    logic          dz_req;

`ifdef SEQDIV_DIVZERO_EN
    logic dz_q, dz_d;
    assign dz_req   = (divider == '0);
    assign div_zero = dz_q;
`else
    assign dz_req = 1'b0;
`endif

    // The stored partial remainder is always < D, so it fits in N bits; the
    // (N+1)-th bit only exists transiently after the shift and feeds the compare.
    assign shift_r = {r_q, q_q[N-1]};
    assign ge      = shift_r[N] | (shift_r[N-1:0] >= d_q);
    assign r_next  = ge ? (shift_r[N-1:0] - d_q) : shift_r[N-1:0];
    assign q_next  = {q_q[N-2:0], ge};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef SEQDIV_DIVZERO_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef SEQDIV_DIVZERO_EN
                    dz_d = dz_req;
`endif
                    if (dz_req) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = S_DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divider;
                        cnt_d   = CW'(N);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_next;
                    rem_d   = r_next;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef SEQDIV_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef SEQDIV_DIVZERO_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = (state_q == S_CALC);
    assign done      = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider_n.sv
// Randomized self-checking bench for seq_divider_n against an arithmetic reference model.
// Builds with or without SEQDIV_DIVZERO_EN.
module tb_seq_divider_n;

    localparam int N   = 7;
    localparam int TMO = 40;
    localparam int ALL = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divider;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef SEQDIV_DIVZERO_EN
    logic         div_zero;
`endif

    int checks = 0;
    int errors = 0;
    int last_q = 0;
    int last_r = 0;

    always #5 clk = ~clk;

    seq_divider_n #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divider   (divider),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
`ifdef SEQDIV_DIVZERO_EN
        .div_zero  (div_zero),
`endif
        .remainder (remainder)
    );

    function automatic void model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = ALL;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input int b);
`ifdef SEQDIV_DIVZERO_EN
        return (b == 0) ? 0 : N;
`else
        return N;
`endif
    endfunction

    // One full operation issued at the next negedge; inj pokes start during CALC and DONE.
    task automatic run_div(input int a, input int b, input bit inj);
        int q, r, k, busy_cnt, lat;
        bit hold_bad;
        model(a, b, q, r);
        lat = exp_lat(b);
        @(negedge clk);
        start = 1'b1; dividend = a[N-1:0]; divider = b[N-1:0];
        @(posedge clk); #1;
        start = 1'b0; dividend = N'($urandom); divider = N'($urandom);
`ifdef SEQDIV_DIVZERO_EN
        checks++;
        if (div_zero !== (b == 0)) begin
            errors++; $display("FAIL div_zero_flag %0d/%0d: got %0b expected %0b", a, b, div_zero, (b == 0));
        end
`endif
        k = 0; busy_cnt = 0; hold_bad = 1'b0;
        while (!done && k < TMO) begin
            if (busy) busy_cnt++;
            if (quotient !== last_q[N-1:0] || remainder !== last_r[N-1:0]) hold_bad = 1'b1;
            if (inj && k == 2) begin
                start = 1'b1; dividend = 7'd99; divider = 7'd3;
            end else start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        checks++;
        if (k !== lat) begin
            errors++; $display("FAIL latency %0d/%0d: got %0d edges expected %0d", a, b, k, lat);
        end
        checks++;
        if (busy_cnt !== lat) begin
            errors++; $display("FAIL busy_cycles %0d/%0d: got %0d expected %0d", a, b, busy_cnt, lat);
        end
        checks++;
        if (hold_bad) begin
            errors++; $display("FAIL output_hold %0d/%0d: outputs moved before completion, expected %0d r %0d", a, b, last_q, last_r);
        end
        checks++;
        if (quotient !== q[N-1:0]) begin
            errors++; $display("FAIL quotient %0d/%0d: got %0d expected %0d", a, b, quotient, q);
        end
        checks++;
        if (remainder !== r[N-1:0]) begin
            errors++; $display("FAIL remainder %0d/%0d: got %0d expected %0d", a, b, remainder, r);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_in_done %0d/%0d: got %0b expected 0", a, b, busy);
        end
        if (inj) begin
            start = 1'b1; dividend = 7'd120; divider = 7'd7;
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse %0d/%0d: got done=%0b busy=%0b expected 0 0", a, b, done, busy);
        end
        checks++;
        if (quotient !== q[N-1:0] || remainder !== r[N-1:0]) begin
            errors++; $display("FAIL result_hold %0d/%0d: got %0d r %0d expected %0d r %0d", a, b, quotient, remainder, q, r);
        end
`ifdef SEQDIV_DIVZERO_EN
        checks++;
        if (div_zero !== (b == 0)) begin
            errors++; $display("FAIL div_zero_hold %0d/%0d: got %0b expected %0b", a, b, div_zero, (b == 0));
        end
`endif
        last_q = q;
        last_r = r;
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s_ctrl: got busy=%0b done=%0b expected 0 0", tag, busy, done);
        end
        checks++;
        if (quotient !== '0 || remainder !== '0) begin
            errors++; $display("FAIL %s_data: got %0d r %0d expected 0 r 0", tag, quotient, remainder);
        end
`ifdef SEQDIV_DIVZERO_EN
        checks++;
        if (div_zero !== 1'b0) begin
            errors++; $display("FAIL %s_div_zero: got %0b expected 0", tag, div_zero);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divider = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        last_q = 0; last_r = 0;
    endtask

    task automatic test_basic();
        run_div(11, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_div(12, 5, 1'b0);
        run_div(15, 3, 1'b0);
        run_div(100, 55, 1'b0);
    endtask

    task automatic test_boundary();
        run_div(127, 1, 1'b0);
        run_div(3, 7, 1'b0);
        run_div(0, 9, 1'b0);
        run_div(127, 127, 1'b0);
    endtask

    task automatic test_div_zero();
        run_div(42, 0, 1'b0);
        run_div(11, 5, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_div(100, 55, 1'b1);
        run_div(127, 10, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; dividend = 7'd100; divider = 7'd55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("reset_mid");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        last_q = 0; last_r = 0;
        saw_done = 1'b0;
        repeat (N + 3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL reset_mid_no_done: got done pulse expected none");
        end
        run_div(11, 5, 1'b0);
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, ALL));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, ALL));
            run_div(a, b, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_n.md
# seq_divider_n

Multi-cycle, parametrised unsigned integer divider producing both quotient and remainder of two N-bit operands. It uses a restoring shift/subtract algorithm, one quotient bit per clock, with a start/busy/done handshake. It supersedes the combinational N-bit remainder block in the arithmetic datapath, where a registered, area-cheap divider with a quotient output is needed.

## Interface
- `N`, default 7: operand and result width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  N  unsigned dividend; sampled with `start`.
- `divider`  in  N  unsigned divisor; sampled with `start`.
- `busy`  out  1  high while a division is in progress (CALC).
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  N  registered quotient.
- `remainder`  out  N  registered remainder.
- `div_zero`  out  1  divide-by-zero flag (present only with `SEQDIV_DIVZERO_EN`).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with `start`=1: latch `dividend` into shift register Q and `divider` into D, clear partial remainder R (N+1 bits), load count = N, go to CALC. `start`=0: stay.
- CALC, each cycle: {R,Q} shifted left by 1. T = R − {0,D} (N+1 bits). If T ≥ 0, R←T and Q[0]←1. Otherwise R is unchanged and Q[0]←0. Decrement count. When count reaches 0 after the update, go to DONE.
- DONE: `done`=1 for exactly one cycle; go to IDLE unconditionally. `start` is ignored in DONE.
- `start` is ignored in CALC. Operand inputs are don't-care outside the sampling edge.
- `quotient` = Q and `remainder` = R[N-1:0]. Both are updated only on the CALC→DONE transition, and are held stable until the next completion or reset.
- Identity at completion: dividend = quotient·divider + remainder, with remainder < divider (divider ≠ 0).
- Divider = 0 without the macro: the algorithm runs normally and yields quotient = 2^N−1 and remainder = dividend.
- Reset values: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0.

## Timing
- Start accepted at edge E0. CALC occupies edges E1..EN, and results are registered at EN. `done` is high in the cycle after EN and is sampled at EN+1. Total latency is N+1 cycles from accept to `done` sample.
- `busy` goes high after E0 and low after EN. It is low during the DONE cycle.
- Back-to-back throughput: a new `start` is accepted at EN+2 at the earliest, i.e. N+2 cycles per operation.
- `rst_n` low mid-operation: immediate return to IDLE, with all outputs at reset values. The in-flight result is discarded and no `done` is emitted.
- `rst_n` deasserts synchronously to `clk` externally. The first `start` is accepted at the first rising edge with `rst_n`=1.

## Configuration
- `SEQDIV_DIVZERO_EN` defined:
  - `div_zero` port exists.
  - IDLE with `start`=1 and `divider`=0 goes directly to DONE with no CALC cycles. It loads quotient = all ones and remainder = dividend, and asserts `div_zero` together with `done`.
  - `div_zero` is held until the next accepted `start` or reset.
  - Latency for this case is 1 cycle to `done`.
- Not defined: no `div_zero` port. Divide-by-zero takes the full N+1 cycles with the natural result described under Operation.

## Test plan
- N=7, 11/5 → quotient=2, remainder=1; `done` sampled exactly 8 edges after the start edge, with `busy` high for 7 cycles.
- N=7, 12/5 → 2 r 2; 15/3 → 5 r 0; 100/55 → 1 r 45, issued back-to-back at the earliest legal starts. Each run gets one `done` pulse and the outputs hold between runs.
- N=7, boundary cases:
  - 127/1 → 127 r 0.
  - 3/7 → 0 r 3.
  - 0/9 → 0 r 0.
  - 127/127 → 1 r 0.
- N=7, `divider`=0, `dividend`=42:
  - Without the macro → quotient=127, remainder=42 after 8 cycles.
  - With the macro → same values, `div_zero`=1, `done` 1 cycle after start.
- `start` pulsed during CALC and in the DONE cycle with different operands → ignored; the original result is delivered unchanged.
- `rst_n` asserted at the 3rd CALC cycle of 100/55 → outputs return to 0 immediately and no `done` follows. A fresh 11/5 after release → 2 r 1.
